// File: rtl/rx_buffer_if.sv
// Bus bundle for rx_buffer: receive-engine handshake plus the CPU read/status port.
// The master side is the engine/CPU; the slave side is the buffer itself.
interface rx_buffer_if #(
   parameter int unsigned AW = 3
);
   logic          rx_rdy;
   logic [7:0]    rx_data;
   logic          perr;
   logic          ferr;
   logic          ovf;
   logic          read_0;
   logic          cpu_rd;
   logic          stat_clr;
   logic [7:0]    dout;
   logic [2:0]    err_out;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          drop;

   modport master (
      output rx_rdy, rx_data, perr, ferr, ovf, cpu_rd, stat_clr,
      input  read_0, dout, err_out, empty, full, count, drop
   );

   modport slave (
      input  rx_rdy, rx_data, perr, ferr, ovf, cpu_rd, stat_clr,
      output read_0, dout, err_out, empty, full, count, drop
   );
endinterface

// File: rtl/rx_buffer.sv
// Receive FIFO between the UART engine and the CPU, with a show-ahead read port.
// Define RX_ERR_TAG_EN to store {perr,ferr,ovf} alongside each byte.
module rx_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input logic        clk,
   input logic        reset,
   rx_buffer_if.slave bus
);
`ifdef RX_ERR_TAG_EN
   localparam int unsigned EW = 11;
`else
   localparam int unsigned EW = 8;
`endif

   typedef enum logic [1:0] {IDLE, CAP, ACK, WAIT} state_t;

   state_t        state;
   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic          drop_q;
   logic          read_q;
   logic          full;
   logic          pop;
   logic          wr;
   logic [EW-1:0] entry;

   assign full = (count_q == (AW+1)'(DEPTH));
   assign pop  = bus.cpu_rd && (count_q != '0);
   // A pop on the capture edge frees the slot, so a full FIFO still accepts the byte.
   assign wr   = (state == CAP) && (!full || pop);

`ifdef RX_ERR_TAG_EN
   assign entry       = {bus.perr, bus.ferr, bus.ovf, bus.rx_data};
   assign bus.dout    = mem[rd_ptr][7:0];
   assign bus.err_out = mem[rd_ptr][10:8];
`else
   logic unused_err;
   assign unused_err  = ^{bus.perr, bus.ferr, bus.ovf};
   assign entry       = bus.rx_data;
   assign bus.dout    = mem[rd_ptr];
   assign bus.err_out = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         drop_q  <= 1'b0;
         read_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         read_q <= (state == CAP);

         case (state)
            IDLE:    if (bus.rx_rdy) state <= CAP;
            CAP:     state <= ACK;
            ACK:     state <= WAIT;
            WAIT:    if (!bus.rx_rdy) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (wr) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);

         case ({wr, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase

         if ((state == CAP) && full && !pop) drop_q <= 1'b1;
         else if (bus.stat_clr)              drop_q <= 1'b0;
      end
   end

   assign bus.read_0 = read_q;
   assign bus.count  = count_q;
   assign bus.empty  = (count_q == '0);
   assign bus.full   = full;
   assign bus.drop   = drop_q;
endmodule

// File: tb/tb_rx_buffer.sv
// Directed self-checking bench for rx_buffer (DEPTH=8); err_out expectations follow RX_ERR_TAG_EN.
module tb_rx_buffer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   always #5 clk = ~clk;

   rx_buffer_if #(.AW(3)) bus ();

   rx_buffer #(.DEPTH(8), .AW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always @(negedge clk) if (bus.read_0 === 1'b1) pulses++;

   function automatic logic [2:0] exp_err(input logic [2:0] e);
`ifdef RX_ERR_TAG_EN
      return e;
`else
      return 3'b000;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [7:0] d, input logic [2:0] e, input bit pop_cap, input bit clr_cap);
      bus.rx_rdy  = 1'b1;
      bus.rx_data = d;
      {bus.perr, bus.ferr, bus.ovf} = e;
      tick();
      bus.cpu_rd   = pop_cap;
      bus.stat_clr = clr_cap;
      tick();
      bus.cpu_rd   = 1'b0;
      bus.stat_clr = 1'b0;
      checks++;
      if (bus.read_0 !== 1'b1) begin
         errors++;
         $display("FAIL read_0_ack got %b want 1 (byte %h)", bus.read_0, d);
      end
      bus.rx_rdy = 1'b0;
      {bus.perr, bus.ferr, bus.ovf} = 3'b000;
      tick();
      tick();
   endtask

   task automatic pop();
      bus.cpu_rd = 1'b1;
      tick();
      bus.cpu_rd = 1'b0;
   endtask

   task automatic test_reset();
      int p0;
      reset = 1'b0;
      tick();
      tick();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", bus.full); end
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count); end
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", bus.drop); end
      checks++; if (bus.read_0 !== 1'b0) begin errors++; $display("FAIL rst_read_0 got %b want 0", bus.read_0); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h want 00", bus.dout); end
      checks++; if (bus.err_out !== 3'b000) begin errors++; $display("FAIL rst_err_out got %b want 000", bus.err_out); end
      reset = 1'b1;
      tick();

      // reset asserted while the FSM sits in WAIT with one byte stored
      bus.rx_rdy = 1'b1; bus.rx_data = 8'h5A;
      tick(); tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstw_empty got %b want 1", bus.empty); end
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rstw_count got %0d want 0", bus.count); end
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL rstw_drop got %b want 0", bus.drop); end
      checks++; if (bus.read_0 !== 1'b0) begin errors++; $display("FAIL rstw_read_0 got %b want 0", bus.read_0); end
      bus.rx_rdy = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      // reset during CAP must abandon the byte with no acknowledge
      p0 = pulses;
      bus.rx_rdy = 1'b1; bus.rx_data = 8'h66;
      tick();
      reset = 1'b0;
      bus.rx_rdy = 1'b0;
      tick();
      reset = 1'b1;
      tick(); tick();
      checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rstc_pulses got %0d want 0", pulses - p0); end
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rstc_count got %0d want 0", bus.count); end

      capture(8'hA5, 3'b000, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL rst_a5_dout got %h want a5", bus.dout); end
      checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL rst_a5_count got %0d want 1", bus.count); end
      pop();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_a5_empty got %b want 1", bus.empty); end
   endtask

   task automatic test_single();
      int p0;
      p0 = pulses;
      capture(8'h3C, 3'b100, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL single_dout got %h want 3c", bus.dout); end
      checks++; if (bus.err_out !== exp_err(3'b100)) begin errors++; $display("FAIL single_err got %b want %b", bus.err_out, exp_err(3'b100)); end
      checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.count); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_nonempty got %b want 0", bus.empty); end
      checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses - p0); end
      pop();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", bus.empty); end
      // pop on empty is ignored
      pop();
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL empty_pop_count got %0d want 0", bus.count); end
   endtask

   task automatic test_overflow();
      int p0;
      p0 = pulses;
      for (int i = 1; i <= 9; i++) capture(8'(i), 3'b000, 1'b0, 1'b0);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.full); end
      checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", bus.count); end
      checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL ovf_drop got %b want 1", bus.drop); end
      checks++; if (pulses - p0 !== 9) begin errors++; $display("FAIL ovf_pulses got %0d want 9", pulses - p0); end
      for (int i = 1; i <= 8; i++) begin
         checks++; if (bus.dout !== 8'(i)) begin errors++; $display("FAIL ovf_drain got %h want %h", bus.dout, 8'(i)); end
         pop();
      end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b want 1", bus.empty); end
      checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL ovf_drop_sticky got %b want 1", bus.drop); end
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", bus.drop); end
   endtask

   task automatic test_wrap();
      logic [7:0] b;
      logic [2:0] e;
      for (int i = 0; i < 20; i++) begin
         b = 8'h10 + 8'(i);
         e = 3'(i);
         capture(b, e, 1'b0, 1'b0);
         checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL wrap_count got %0d want 1 (i=%0d)", bus.count, i); end
         checks++; if (bus.dout !== b) begin errors++; $display("FAIL wrap_dout got %h want %h", bus.dout, b); end
         checks++; if (bus.err_out !== exp_err(e)) begin errors++; $display("FAIL wrap_err got %b want %b", bus.err_out, exp_err(e)); end
         pop();
         checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1 (i=%0d)", bus.empty, i); end
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) capture(8'h40 + 8'(i), 3'b000, 1'b0, 1'b0);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL sim_full got %b want 1", bus.full); end
      capture(8'hEE, 3'b011, 1'b1, 1'b0);
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL sim_drop got %b want 0", bus.drop); end
      checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL sim_count got %0d want 8", bus.count); end
      for (int i = 1; i < 8; i++) begin
         checks++; if (bus.dout !== 8'h40 + 8'(i)) begin errors++; $display("FAIL sim_drain got %h want %h", bus.dout, 8'h40 + 8'(i)); end
         pop();
      end
      checks++; if (bus.dout !== 8'hEE) begin errors++; $display("FAIL sim_last got %h want ee", bus.dout); end
      checks++; if (bus.err_out !== exp_err(3'b011)) begin errors++; $display("FAIL sim_last_err got %b want %b", bus.err_out, exp_err(3'b011)); end
      pop();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sim_empty got %b want 1", bus.empty); end

      // drop set wins over a coincident stat_clr
      for (int i = 0; i < 8; i++) capture(8'h50 + 8'(i), 3'b000, 1'b0, 1'b0);
      capture(8'h99, 3'b000, 1'b0, 1'b1);
      checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL sim_setclr got %b want 1", bus.drop); end
      checks++; if (bus.dout !== 8'h50) begin errors++; $display("FAIL sim_head got %h want 50", bus.dout); end
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL sim_clr got %b want 0", bus.drop); end
      for (int i = 0; i < 8; i++) pop();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sim_empty2 got %b want 1", bus.empty); end
   endtask

   task automatic test_held_rx_rdy();
      int p0;
      p0 = pulses;
      bus.rx_rdy = 1'b1; bus.rx_data = 8'h77;
      tick();
      tick();
      checks++; if (bus.read_0 !== 1'b1) begin errors++; $display("FAIL held_ack got %b want 1", bus.read_0); end
      tick(); tick(); tick();
      checks++; if (bus.read_0 !== 1'b0) begin errors++; $display("FAIL held_read_0 got %b want 0", bus.read_0); end
      checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL held_count got %0d want 1", bus.count); end
      bus.rx_rdy = 1'b0;
      tick(); tick();
      checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL held_count2 got %0d want 1", bus.count); end
      checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses - p0); end
      checks++; if (bus.dout !== 8'h77) begin errors++; $display("FAIL held_dout got %h want 77", bus.dout); end
      pop();
   endtask

   initial begin
      bus.rx_rdy   = 1'b0;
      bus.rx_data  = 8'h00;
      bus.perr     = 1'b0;
      bus.ferr     = 1'b0;
      bus.ovf      = 1'b0;
      bus.cpu_rd   = 1'b0;
      bus.stat_clr = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_wrap();
      test_simultaneous();
      test_held_rx_rdy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
